xbar_cfg_arbiter: RTL
=====================

# xbar_cfg_arbiter

- Shares the crossbar `control` / `control_val` / `control_rdy` port between two configuration requesters: the Wishbone-side config path (requester 0) and the GPIO config pins (requester 1).
- Arbitration is round-robin. The winning config word is registered and issued to the crossbar with a val/rdy handshake.
- After each applied configuration, a guard interval blocks new reconfiguration so in-flight stream traffic can settle.
- Sits between the Wishbone/GPIO config sources and each `crossbarVRTL` instance in the demo wrapper.

## Interface
Parameters:
- `CONTROL_BIT_WIDTH`, default 2: width of a crossbar config word.
- `GUARD_CYCLES`, default 4: idle cycles enforced after each control handshake. 0 disables the guard.
- `CNT_WIDTH`, default 8: width of the applied-config counter.

Ports:
- `clk`, input, 1: single clock.
- `reset`, input, 1: asynchronous, active-high.
- `req0_config`, input, `CONTROL_BIT_WIDTH`: Wishbone-side config word.
- `req0_val`, input, 1: requester 0 valid.
- `req0_rdy`, output, 1: requester 0 accepted.
- `req1_config`, input, `CONTROL_BIT_WIDTH`: GPIO config word.
- `req1_val`, input, 1: requester 1 valid.
- `req1_rdy`, output, 1: requester 1 accepted.
- `control`, output, `CONTROL_BIT_WIDTH`: config word to the crossbar.
- `control_val`, output, 1: crossbar control valid.
- `control_rdy`, input, 1: crossbar control ready.
- `busy`, output, 1: high in every state except IDLE.
- `grant_id`, output, 1: requester whose config was accepted most recently.
- `cfg_count`, output, `CNT_WIDTH`: applied-config count. Present only with the macro below.

## Operation
State machine states: IDLE, ISSUE, GUARD.

IDLE:
- `req*_rdy` is combinational: the granted requester's rdy is high when its val is high.
- A transfer on a requester occurs when its val and rdy are both high.
- Only one val high: that requester wins.
- Both val high: the requester selected by the priority pointer wins.
- On acceptance:
  - capture the winner's config into the `control` register;
  - `grant_id` ← winner;
  - priority pointer ← the other requester;
  - go to ISSUE.

ISSUE:
- `control_val` = 1. `control` is held stable.
- Both `req*_rdy` = 0.
- On `control_rdy`:
  - if `GUARD_CYCLES` = 0, go to IDLE;
  - otherwise load guard counter ← `GUARD_CYCLES`−1 and go to GUARD.

GUARD:
- `control_val` = 0, both rdy = 0.
- Counter decrements each cycle. At 0, go to IDLE.
- Requests arriving during GUARD are held off, not dropped; requesters keep val asserted.

Other rules:
- The pointer updates only on acceptance. A lone requester may win repeatedly.
- `control` retains the last applied word while in IDLE and GUARD.

Reset, asynchronous, at any time, including mid-ISSUE or mid-GUARD:
- state = IDLE;
- `control` = 0, `control_val` = 0, `req*_rdy` = 0 when no val is high;
- `busy` = 0, `grant_id` = 0;
- pointer = 0 (requester 0 preferred), guard counter = 0, `cfg_count` = 0.

An aborted ISSUE is not replayed.

## Timing
- Acceptance in cycle T gives `control_val` = 1 from cycle T+1.
- With `control_rdy` high in T+1:
  - GUARD occupies T+2 … T+1+`GUARD_CYCLES`;
  - the next acceptance is possible at the earliest in T+2+`GUARD_CYCLES`.
- `control_rdy` low stalls ISSUE indefinitely with `control` stable.
- Requester val→rdy is same-cycle (combinational) in IDLE only.

## Configuration
- Macro `XBAR_CFG_ARB_COUNT_EN`.
- Defined:
  - the `cfg_count` port exists;
  - it increments by 1 on each ISSUE handshake (`control_val` & `control_rdy`);
  - it wraps from 2^`CNT_WIDTH`−1 to 0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - the state enum (IDLE = 0, ISSUE = 1, GUARD = 2);
  - requester ID constants: WB = 0, GPIO = 1.
- One sub-module, `xbar_cfg_rr_arb`. It is a combinational 2-way round-robin grant plus the registered priority pointer, updated on an accept strobe.

## Test plan
Default parameters, with `XBAR_CFG_ARB_COUNT_EN` defined.
- **Reset:** assert reset mid-run → `control` = 0, `control_val` = 0, `busy` = 0, `grant_id` = 0, `cfg_count` = 0.
- **Single request:** `req0_val` = 1, `req0_config` = 2'b10, `control_rdy` = 1:
  - `req0_rdy` = 1 in T;
  - `control` = 2'b10 and `control_val` = 1 in T+1;
  - `busy` in T+1..T+5, then IDLE in T+6;
  - `cfg_count` = 1.
- **Simultaneous requests:** both val held high, configs 2'b01 and 2'b11 → grants alternate 0, 1, 0, 1. Accepts are spaced exactly 6 cycles apart.
- **Stalled ISSUE:** `control_rdy` = 0 for 10 cycles → `control_val` stays 1, `control` stable, both rdy stay 0. Raising `control_rdy` enters GUARD the next cycle.
- **Guard disabled:** `GUARD_CYCLES` = 0, back-to-back requests → accept every 2 cycles.
- **Wrap-around and mid-ISSUE reset:** `CNT_WIDTH` = 2 with 5 handshakes → `cfg_count` = 1. Reset during ISSUE → `control_val` drops immediately and no handshake is counted.

Source files
------------

// File: rtl/xbar_cfg_arbiter_pkg.sv
// rtl/xbar_cfg_arbiter_pkg.sv - shared state encoding and requester IDs for the crossbar config arbiter
package xbar_cfg_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    localparam logic REQ_WB   = 1'b0;
    localparam logic REQ_GPIO = 1'b1;

endpackage

// File: rtl/xbar_cfg_arbiter_if.sv
// rtl/xbar_cfg_arbiter_if.sv - requester/crossbar handshake bundle; cfg_count only with XBAR_CFG_ARB_COUNT_EN
interface xbar_cfg_arbiter_if #(
    parameter int CONTROL_BIT_WIDTH = 2,
    parameter int CNT_WIDTH         = 8
);
    logic [CONTROL_BIT_WIDTH-1:0] req0_config;
    logic                         req0_val;
    logic                         req0_rdy;
    logic [CONTROL_BIT_WIDTH-1:0] req1_config;
    logic                         req1_val;
    logic                         req1_rdy;
    logic [CONTROL_BIT_WIDTH-1:0] control;
    logic                         control_val;
    logic                         control_rdy;
    logic                         busy;
    logic                         grant_id;
`ifdef XBAR_CFG_ARB_COUNT_EN
    logic [CNT_WIDTH-1:0]         cfg_count;

    modport slave (
        input  req0_config, req0_val, req1_config, req1_val, control_rdy,
        output req0_rdy, req1_rdy, control, control_val, busy, grant_id, cfg_count
    );
    modport master (
        output req0_config, req0_val, req1_config, req1_val, control_rdy,
        input  req0_rdy, req1_rdy, control, control_val, busy, grant_id, cfg_count
    );
`else
    modport slave (
        input  req0_config, req0_val, req1_config, req1_val, control_rdy,
        output req0_rdy, req1_rdy, control, control_val, busy, grant_id
    );
    modport master (
        output req0_config, req0_val, req1_config, req1_val, control_rdy,
        input  req0_rdy, req1_rdy, control, control_val, busy, grant_id
    );
`endif
endinterface

// File: rtl/xbar_cfg_rr_arb.sv
// rtl/xbar_cfg_rr_arb.sv - two-way round-robin grant with registered priority pointer
module xbar_cfg_rr_arb
    import xbar_cfg_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic val0_i,
    input  logic val1_i,
    input  logic accept_i,
    output logic grant_o
);
    logic ptr_q, ptr_d;

    // Pointer only matters on contention; a lone requester always wins.
    assign grant_o = (val0_i && val1_i) ? ptr_q : val1_i;
    assign ptr_d   = accept_i ? ~grant_o : ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= REQ_WB;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/xbar_cfg_arbiter.sv
// rtl/xbar_cfg_arbiter.sv - shares crossbar control port between WB and GPIO config; XBAR_CFG_ARB_COUNT_EN adds cfg_count
module xbar_cfg_arbiter
    import xbar_cfg_arbiter_pkg::*;
#(
    parameter int CONTROL_BIT_WIDTH = 2,
    parameter int GUARD_CYCLES      = 4,
    parameter int CNT_WIDTH         = 8
)(
    input  logic               clk,
    input  logic               reset,
    xbar_cfg_arbiter_if.slave  bus
);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

    state_e                       state_q, state_d;
    logic [CONTROL_BIT_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                         gid_q, gid_d;
    logic [GW-1:0]                guard_q, guard_d;
    logic                         accept;
    logic                         win_id;

    assign accept = (state_q == ST_IDLE) && (bus.req0_val || bus.req1_val);

    xbar_cfg_rr_arb u_rr (
        .clk      (clk),
        .reset    (reset),
        .val0_i   (bus.req0_val),
        .val1_i   (bus.req1_val),
        .accept_i (accept),
        .grant_o  (win_id)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            gid_q   <= REQ_WB;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            gid_q   <= gid_d;
            guard_q <= guard_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        gid_d   = gid_q;
        guard_d = guard_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                    ctrl_d  = win_id ? bus.req1_config : bus.req0_config;
                    gid_d   = win_id;
                end
            end
            ST_ISSUE: begin
                if (bus.control_rdy) begin
                    if (GUARD_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GUARD;
                        guard_d = GW'(GUARD_CYCLES - 1);
                    end
                end
            end
            ST_GUARD: begin
                if (guard_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req0_rdy    = (state_q == ST_IDLE) && bus.req0_val && (win_id == REQ_WB);
        bus.req1_rdy    = (state_q == ST_IDLE) && bus.req1_val && (win_id == REQ_GPIO);
        bus.control_val = (state_q == ST_ISSUE);
        bus.busy        = (state_q != ST_IDLE);
    end

    assign bus.control  = ctrl_q;
    assign bus.grant_id = gid_q;

`ifdef XBAR_CFG_ARB_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if ((state_q == ST_ISSUE) && bus.control_rdy) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.cfg_count = cnt_q;
`endif
endmodule
